// File: rtl/spc_muldiv_seq_pkg.sv
// Shared types and constants for the SPC700 MUL/DIV sequencer.
// Holds the FSM state enum and the MulDiv secondary-op encodings.
package spc_muldiv_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ITER,
    CAPT,
    PAD,
    FIN
  } MulDivSeqState_t;

  localparam logic [3:0] SEC_OP_LOAD = 4'b0000;
  localparam logic [3:0] SEC_OP_MUL  = 4'b1110;
  localparam logic [3:0] SEC_OP_DIV  = 4'b1111;

  typedef struct packed {
    logic [3:0] secOp;
  } MulDivCtrl_t;

endpackage

// File: rtl/spc_muldiv_seq_muldiv.sv
// Iterative 8x8 multiply / 16/8 divide datapath (MulDiv).
// MUL RES is the value after the current step; DIV RES is registered.
module spc_muldiv_seq_muldiv
  import spc_muldiv_seq_pkg::*;
(
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        EN,
  input  MulDivCtrl_t CTRL,
  input  logic [7:0]  A,
  input  logic [7:0]  X,
  input  logic [7:0]  Y,
  output logic [15:0] RES,
  output logic        V
);

  logic [7:0]  a_q;
  logic [7:0]  x_q;
  logic [15:0] sh_q;
  logic [14:0] acc_q;
  logic [7:0]  r_q;
  logic [8:0]  q_q;

  logic [15:0] acc_n;
  logic [8:0]  t;
  logic [8:0]  diff;
  logic        ge;
  logic [7:0]  r_n;

  // One shift-add (MUL) or restoring-subtract (DIV) step
  always_comb begin
    acc_n = {acc_q, 1'b0} + (sh_q[15] ? {8'h00, a_q} : 16'h0000);
    t     = {r_q, sh_q[8]};
    diff  = t - {1'b0, x_q};
    ge    = (t >= {1'b0, x_q});
    r_n   = ge ? diff[7:0] : t[7:0];
    RES   = (CTRL.secOp == SEC_OP_MUL) ? acc_n : {r_q, q_q[7:0]};
    V     = q_q[8];
  end

  // Operand load and iteration registers
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      a_q   <= '0;
      x_q   <= '0;
      sh_q  <= '0;
      acc_q <= '0;
      r_q   <= '0;
      q_q   <= '0;
    end else if (EN) begin
      case (CTRL.secOp)
        SEC_OP_LOAD: begin
          a_q   <= A;
          x_q   <= X;
          sh_q  <= {Y, A};
          acc_q <= '0;
          r_q   <= {1'b0, Y[7:1]};
          q_q   <= '0;
        end
        SEC_OP_MUL: begin
          acc_q <= acc_n[14:0];
          sh_q  <= {sh_q[14:0], 1'b0};
        end
        SEC_OP_DIV: begin
          r_q  <= r_n;
          q_q  <= {q_q[7:0], ge};
          sh_q <= {sh_q[14:0], 1'b0};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/spc_muldiv_seq.sv
// SPC700 MUL YA / DIV YA,X sequencer around one MulDiv datapath.
// Pads each op to a fixed EN-cycle latency and returns YA plus flags.
module spc_muldiv_seq
  import spc_muldiv_seq_pkg::*;
#(
  parameter int MUL_LAT = 9,
  parameter int DIV_LAT = 12
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic       START,
  input  logic       OP,
  input  logic       ABORT,
  input  logic [7:0] A_IN,
  input  logic [7:0] X_IN,
  input  logic [7:0] Y_IN,
  output logic       BUSY,
  output logic       DONE,
  output logic [7:0] RES_A,
  output logic [7:0] RES_Y,
  output logic       FLG_N,
  output logic       FLG_Z,
  output logic       FLG_V,
  output logic       FLG_H
);

  if (MUL_LAT < 9) begin : g_bad_mul_lat
    $error("MUL_LAT must be >= 9");
  end
  if (DIV_LAT < 11) begin : g_bad_div_lat
    $error("DIV_LAT must be >= 11");
  end

  localparam int MAXLAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW     = $clog2(MAXLAT + 1);

  localparam logic [CW-1:0] K_MUL_LAST = CW'(8);
  localparam logic [CW-1:0] K_DIV_LAST = CW'(9);
  localparam logic [CW-1:0] K_MUL_PAD  = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] K_DIV_PAD  = CW'(DIV_LAT - 1);
  localparam bit            MUL_PADS   = (MUL_LAT > 9);
  localparam bit            DIV_PADS   = (DIV_LAT > 11);

  MulDivSeqState_t state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            accept;
  logic            mid;

  logic            op_q;
  logic [7:0]      a_q, x_q, y_q;
  logic            h_q;

  logic [3:0]      sec_op;
  logic            dp_en;
  logic            cap_mul;
  logic            cap_div;
  MulDivCtrl_t     ctrl;
  logic [15:0]     dp_res;
  logic            dp_v;

  assign mid  = (state_q == LOAD) || (state_q == ITER) ||
                (state_q == CAPT) || (state_q == PAD);
  assign BUSY = (state_q != IDLE);
  assign DONE = (state_q == FIN);
  assign ctrl = '{secOp: sec_op};

  // State and step counter register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: step through the phases, abort, back-to-back accept
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    if (EN) begin
      unique case (state_q)
        IDLE: accept = START;
        LOAD: begin
          state_d = ITER;
          cnt_d   = cnt_q + 1'b1;
        end
        ITER: begin
          cnt_d = cnt_q + 1'b1;
          if (!op_q && cnt_q == K_MUL_LAST)
            state_d = MUL_PADS ? PAD : FIN;
          else if (op_q && cnt_q == K_DIV_LAST)
            state_d = CAPT;
        end
        CAPT: begin
          cnt_d   = cnt_q + 1'b1;
          state_d = DIV_PADS ? PAD : FIN;
        end
        PAD: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == (op_q ? K_DIV_PAD : K_MUL_PAD))
            state_d = FIN;
        end
        FIN: begin
          accept  = START;
          state_d = IDLE;
          cnt_d   = '0;
        end
        default: state_d = IDLE;
      endcase
      if (ABORT && mid) begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      if (accept) begin
        state_d = LOAD;
        cnt_d   = '0;
      end
    end
  end

  // Datapath control and capture strobes per state
  always_comb begin
    sec_op  = SEC_OP_LOAD;
    dp_en   = 1'b0;
    cap_mul = 1'b0;
    cap_div = 1'b0;
    unique case (state_q)
      LOAD: dp_en = EN;
      ITER: begin
        sec_op  = op_q ? SEC_OP_DIV : SEC_OP_MUL;
        dp_en   = EN;
        cap_mul = EN && !ABORT && !op_q &&
                  (cnt_q == K_MUL_LAST);
      end
      CAPT: begin
        sec_op  = SEC_OP_DIV;
        cap_div = EN && !ABORT;
      end
      default: ;
    endcase
  end

  // Operand latches, loaded only on START acceptance
  always_ff @(posedge CLK) begin
    if (RST) begin
      op_q <= 1'b0;
      a_q  <= '0;
      x_q  <= '0;
      y_q  <= '0;
    end else if (accept) begin
      op_q <= OP;
      a_q  <= A_IN;
      x_q  <= X_IN;
      y_q  <= Y_IN;
    end
  end

  // Half-carry for DIV, taken from the latched operands at LOAD
  always_ff @(posedge CLK) begin
    if (RST)
      h_q <= 1'b0;
    else if (EN && state_q == LOAD)
      h_q <= (y_q[3:0] >= x_q[3:0]);
  end

  // Result and flag registers, written only on a capture
  always_ff @(posedge CLK) begin
    if (RST) begin
      RES_A <= '0;
      RES_Y <= '0;
      FLG_N <= 1'b0;
      FLG_Z <= 1'b0;
      FLG_V <= 1'b0;
      FLG_H <= 1'b0;
    end else if (cap_mul) begin
      RES_A <= dp_res[7:0];
      RES_Y <= dp_res[15:8];
      FLG_N <= dp_res[15];
      FLG_Z <= (dp_res[15:8] == 8'h00);
      FLG_V <= 1'b0;
      FLG_H <= 1'b0;
    end else if (cap_div) begin
      RES_A <= dp_res[7:0];
      RES_Y <= dp_res[15:8];
      FLG_N <= dp_res[7];
      FLG_Z <= (dp_res[7:0] == 8'h00);
      FLG_V <= dp_v;
      FLG_H <= h_q;
    end
  end

  spc_muldiv_seq_muldiv u_muldiv (
    .CLK   (CLK),
    .RST_N (~RST),
    .EN    (dp_en),
    .CTRL  (ctrl),
    .A     (a_q),
    .X     (x_q),
    .Y     (y_q),
    .RES   (dp_res),
    .V     (dp_v)
  );

endmodule

// File: tb/tb_spc_muldiv_seq.sv
// Scoreboard bench for spc_muldiv_seq.
// Expected YA/flags are queued at START and popped at DONE.
module tb_spc_muldiv_seq;

  localparam int MUL_LAT = 9;
  localparam int DIV_LAT = 12;

  logic       clk = 1'b0;
  logic       rst, en, start, op, abort;
  logic [7:0] a_in, x_in, y_in;
  logic       busy, done;
  logic [7:0] res_a, res_y;
  logic       fn, fz, fv, fh;
  logic [19:0] obs;

  typedef logic [19:0] exp_t;
  exp_t sbq[$];
  exp_t last_exp;
  int   checks;
  int   failures;
  logic prev_done;

  assign obs = {res_y, res_a, fn, fz, fv, fh};

  always #5 clk = ~clk;

  spc_muldiv_seq #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) dut (
    .CLK   (clk),
    .RST   (rst),
    .EN    (en),
    .START (start),
    .OP    (op),
    .ABORT (abort),
    .A_IN  (a_in),
    .X_IN  (x_in),
    .Y_IN  (y_in),
    .BUSY  (busy),
    .DONE  (done),
    .RES_A (res_a),
    .RES_Y (res_y),
    .FLG_N (fn),
    .FLG_Z (fz),
    .FLG_V (fv),
    .FLG_H (fh)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic o,
                                 input logic [7:0] a,
                                 input logic [7:0] x,
                                 input logic [7:0] y);
    logic [15:0] p, d, q, r;
    logic        h;
    if (!o) begin
      p = 16'(y) * 16'(a);
      return {p[15:8], p[7:0], p[15],
              p[15:8] == 8'h00, 1'b0, 1'b0};
    end
    d = {y, a};
    q = d / {8'h00, x};
    r = d % {8'h00, x};
    h = (y[3:0] >= x[3:0]);
    return {r[7:0], q[7:0], q[7],
            q[7:0] == 8'h00, q[8], h};
  endfunction

  task automatic start_op(input logic o,
                          input logic [7:0] a,
                          input logic [7:0] x,
                          input logic [7:0] y,
                          input bit push);
    start = 1'b1;
    op    = o;
    a_in  = a;
    x_in  = x;
    y_in  = y;
    en    = 1'b1;
    if (push) begin
      last_exp = model(o, a, x, y);
      sbq.push_back(last_exp);
    end
  endtask

  task automatic wait_done(input int lat, input int stall_k,
                           input int stall_n, input int poke_k);
    int k;
    int clks;
    k    = 0;
    clks = 0;
    @(negedge clk);
    start = 1'b0;
    while (!done && k < 64) begin
      check("busy", {31'd0, busy}, 1);
      if (k == poke_k) begin
        start = 1'b1;
        op    = ~op;
        a_in  = 8'h5A;
        x_in  = 8'h03;
        y_in  = 8'hC3;
      end else begin
        start = 1'b0;
      end
      if (k == stall_k) begin
        en = 1'b0;
        repeat (stall_n) begin
          @(negedge clk);
          clks++;
          check("stall_done", {31'd0, done}, 0);
        end
        en = 1'b1;
      end
      @(negedge clk);
      clks++;
      k++;
    end
    start = 1'b0;
    check("done", {31'd0, done}, 1);
    check("lat_k", k, lat);
    check("lat_clk", clks, lat + stall_n);
  endtask

  // Scoreboard: pop one expectation per DONE pulse
  initial begin
    exp_t e;
    prev_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        prev_done = 1'b0;
      end else begin
        if (done && !prev_done) begin
          if (sbq.size() == 0) begin
            check("unexp_done", {31'd0, done}, 0);
          end else begin
            e = sbq.pop_front();
            check("result", {12'd0, obs}, {12'd0, e});
          end
        end
        prev_done = done;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int x, y, ymax;
    logic o;
    checks   = 0;
    failures = 0;
    rst   = 1'b1;
    en    = 1'b0;
    start = 1'b0;
    op    = 1'b0;
    abort = 1'b0;
    a_in  = '0;
    x_in  = '0;
    y_in  = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_res", {12'd0, obs}, 0);
    rst = 1'b0;
    en  = 1'b1;
    @(negedge clk);

    start_op(1'b0, 8'h34, 8'h00, 8'h12, 1);
    wait_done(MUL_LAT, -1, 0, -1);
    check("mul_ref", {12'd0, obs}, {12'd0, 8'h03, 8'hA8, 4'b0000});

    start_op(1'b1, 8'h23, 8'h10, 8'h01, 1);
    wait_done(DIV_LAT, -1, 0, 3);
    check("div_ref", {12'd0, obs}, {12'd0, 8'h03, 8'h12, 4'b0001});

    start_op(1'b1, 8'h00, 8'h08, 8'h09, 1);
    wait_done(DIV_LAT, -1, 0, -1);
    check("div_ovf", {12'd0, obs}, {12'd0, 8'h00, 8'h20, 4'b0011});

    start_op(1'b0, 8'h34, 8'h00, 8'h12, 1);
    wait_done(MUL_LAT, 4, 3, -1);
    en = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("fin_hold", {31'd0, done}, 1);
    end
    en = 1'b1;

    start_op(1'b1, 8'h77, 8'h03, 8'h02, 0);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", {31'd0, busy}, 0);
    repeat (16) begin
      @(negedge clk);
      check("abort_done", {31'd0, done}, 0);
    end
    check("abort_hold", {12'd0, obs}, {12'd0, last_exp});

    start_op(1'b1, 8'hFF, 8'h01, 8'h00, 1);
    wait_done(DIV_LAT, -1, 0, -1);
    start_op(1'b0, 8'hFF, 8'h00, 8'hFF, 1);
    wait_done(MUL_LAT, -1, 0, -1);
    start_op(1'b1, 8'h05, 8'h07, 8'h00, 1);
    wait_done(DIV_LAT, -1, 0, -1);
    start_op(1'b0, 8'h00, 8'h44, 8'h9B, 1);
    wait_done(MUL_LAT, -1, 0, -1);

    for (int i = 0; i < 12; i++) begin
      o    = 1'($urandom_range(0, 1));
      x    = int'($urandom_range(1, 255));
      ymax = 2 * x - 1;
      if (ymax > 255) ymax = 255;
      y    = int'($urandom_range(0, ymax));
      start_op(o, 8'($urandom), 8'(x), 8'(y), 1);
      wait_done(o ? DIV_LAT : MUL_LAT, -1, 0, -1);
      if (i % 3 == 0) @(negedge clk);
    end

    @(negedge clk);
    start_op(1'b0, 8'h11, 8'h00, 8'h22, 0);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_busy", {31'd0, busy}, 0);
    check("mrst_done", {31'd0, done}, 0);
    check("mrst_res", {12'd0, obs}, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("mrst_idle", {31'd0, busy}, 0);

    check("sb_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
